// File: rtl/grad_softplus_pkg.sv
// Shared constants, legacy-equivalent coefficient defaults and helper functions
// for the softplus-squared piecewise-linear gradient unit.
package grad_softplus_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_FRAC_W   = 8;
  localparam int DEF_SEG_BITS = 4;
  localparam int DEF_TAG_W    = 4;
  localparam int DEF_N        = 1 << DEF_SEG_BITS;

  // Intercepts reproduce the old piecewise-constant LUT exactly; slopes start flat.
  localparam logic [DEF_DATA_W-1:0] C0_DEF [DEF_N] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0003, 16'h0008, 16'h0014, 16'h002a,
    16'h0044, 16'h005a, 16'h0066, 16'h006b, 16'h006d, 16'h006e, 16'h006e, 16'h006e
  };
  localparam logic [DEF_DATA_W-1:0] C1_DEF [DEF_N] = '{default: 16'h0000};

  // Clamp a signed value to [0, 2^(data_w-1)-1].
  function automatic longint sat_pos(input longint v, input int data_w);
    longint max_v;
    max_v = (longint'(1) << (data_w - 1)) - 1;
    if (v < 0) return 0;
    if (v > max_v) return max_v;
    return v;
  endfunction

  // Map an integer part onto a segment index, pinning out-of-range values to the ends.
  function automatic int seg_clamp(input longint ip, input int seg_bits);
    longint half;
    half = longint'(1) << (seg_bits - 1);
    if (ip < -half) return 0;
    if (ip > half - 1) return int'(2 * half - 1);
    return int'(ip + half);
  endfunction

endpackage

// File: rtl/grad_coef_table.sv
// Intercept/slope register file: one write port, combinational read of both tables.
// Writes land at the clock edge, so a same-cycle read sees the previous contents.
module grad_coef_table
  import grad_softplus_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEG_BITS = DEF_SEG_BITS,
  parameter bit USE_DEF  = 1'b1
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic                i_sel,
  input  logic [SEG_BITS-1:0] i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [SEG_BITS-1:0] i_rd_idx,
  output logic [DATA_W-1:0]   o_rd_c0,
  output logic [DATA_W-1:0]   o_rd_c1
);

  localparam int N = 1 << SEG_BITS;

  logic [DATA_W-1:0] r_c0 [N];
  logic [DATA_W-1:0] r_c1 [N];

  function automatic logic [DATA_W-1:0] def_c0(input int i);
    if (USE_DEF && i < DEF_N) return DATA_W'(C0_DEF[DEF_SEG_BITS'(i)]);
    return '0;
  endfunction

  function automatic logic [DATA_W-1:0] def_c1(input int i);
    if (USE_DEF && i < DEF_N) return DATA_W'(C1_DEF[DEF_SEG_BITS'(i)]);
    return '0;
  endfunction

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        r_c0[i] <= def_c0(i);
        r_c1[i] <= def_c1(i);
      end
    end else if (i_we) begin
      if (i_sel) r_c1[i_addr] <= i_wdata;
      else       r_c0[i_addr] <= i_wdata;
    end
  end

  assign o_rd_c0 = r_c0[i_rd_idx];
  assign o_rd_c1 = r_c1[i_rd_idx];

endmodule

// File: rtl/grad_softplus_sq_pwl.sv
// Piecewise-linear softplus-squared gradient: grad = sat(c0[seg] + c1[seg]*frac), 3-cycle latency.
// Single shared stage enable; when the output is held by out_ready=0 every stage and in_ready stall.
module grad_softplus_sq_pwl
  import grad_softplus_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int SEG_BITS = DEF_SEG_BITS,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_x,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_grad,
  output logic [TAG_W-1:0]    out_tag,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [SEG_BITS-1:0] cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata
);

  localparam int     IP_W    = DATA_W - FRAC_W;
  localparam int     P_W     = DATA_W + FRAC_W + 1;
  localparam longint HALF    = longint'(1) << (SEG_BITS - 1);
  localparam bit     USE_DEF = (DATA_W == DEF_DATA_W) && (FRAC_W == DEF_FRAC_W) &&
                               (SEG_BITS == DEF_SEG_BITS);

  logic                r_v1, r_v2, r_v3;
  logic [SEG_BITS-1:0] r_idx1;
  logic [FRAC_W-1:0]   r_f1;
  logic [TAG_W-1:0]    r_tag1, r_tag2, r_tag3;
  logic [DATA_W-1:0]   r_c0_2;
  logic [DATA_W:0]     r_s2;
  logic [DATA_W-1:0]   r_grad;

  logic                     w_en;
  logic signed [IP_W-1:0]   w_ip;
  logic                     w_lo, w_hi;
  logic [SEG_BITS-1:0]      w_idx;
  logic [FRAC_W-1:0]        w_f;
  logic [DATA_W-1:0]        w_c0, w_c1;
  logic signed [P_W-1:0]    w_p;
  logic [DATA_W:0]          w_s;
  logic signed [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0]        w_grad;

  assign w_en     = !r_v3 || out_ready;
  assign in_ready = w_en;

  // S1: integer part selects the segment; clamped samples pin the fraction to the segment edge.
  assign w_ip  = in_x[DATA_W-1:FRAC_W];
  assign w_lo  = longint'(w_ip) < -HALF;
  assign w_hi  = longint'(w_ip) > HALF - 1;
  assign w_idx = SEG_BITS'(seg_clamp(longint'(w_ip), SEG_BITS));
  assign w_f   = w_lo ? '0 : (w_hi ? '1 : in_x[FRAC_W-1:0]);

  grad_coef_table #(
    .DATA_W   (DATA_W),
    .SEG_BITS (SEG_BITS),
    .USE_DEF  (USE_DEF)
  ) u_coef (
    .clk      (clk),
    .i_rst    (rst),
    .i_we     (cfg_we),
    .i_sel    (cfg_sel),
    .i_addr   (cfg_addr),
    .i_wdata  (cfg_wdata),
    .i_rd_idx (r_idx1),
    .o_rd_c0  (w_c0),
    .o_rd_c1  (w_c1)
  );

  // S2: signed slope times unsigned fraction, floored back to the output scale.
  assign w_p = $signed({{(FRAC_W+1){w_c1[DATA_W-1]}}, w_c1}) *
               $signed({{(DATA_W+1){1'b0}}, r_f1});
  assign w_s = (DATA_W+1)'(w_p >>> FRAC_W);

  // S3
  assign w_sum  = $signed({{2{r_c0_2[DATA_W-1]}}, r_c0_2}) + $signed({r_s2[DATA_W], r_s2});
  assign w_grad = DATA_W'(sat_pos(longint'(w_sum), DATA_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_idx1 <= '0;
      r_f1   <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_c0_2 <= '0;
      r_s2   <= '0;
      r_grad <= '0;
    end else if (w_en) begin
      r_v1   <= in_valid;
      r_idx1 <= w_idx;
      r_f1   <= w_f;
      r_tag1 <= in_tag;
      r_v2   <= r_v1;
      r_c0_2 <= w_c0;
      r_s2   <= w_s;
      r_tag2 <= r_tag1;
      r_v3   <= r_v2;
      r_grad <= w_grad;
      r_tag3 <= r_tag2;
    end
  end

  assign out_valid = r_v3;
  assign out_grad  = r_grad;
  assign out_tag   = r_tag3;

endmodule

// File: tb/tb_grad_softplus_sq_pwl.sv
// Directed bench for grad_softplus_sq_pwl: legacy table, linear segments, saturation,
// backpressure, write/read race and mid-stream reset.
module tb_grad_softplus_sq_pwl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_grad;
  logic [3:0]  out_tag;
  logic        cfg_we;
  logic        cfg_sel;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;

  grad_softplus_sq_pwl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_grad  (out_grad),
    .out_tag   (out_tag),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] LEGACY [16] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0003, 16'h0008, 16'h0014, 16'h002a,
    16'h0044, 16'h005a, 16'h0066, 16'h006b, 16'h006d, 16'h006e, 16'h006e, 16'h006e
  };

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] q_x [$];
  logic [3:0]  q_tag [$];
  logic [15:0] q_eg [$];
  logic [3:0]  q_et [$];

  int          cfg_cyc = -1;
  logic        cfg_sel_v;
  logic [3:0]  cfg_addr_v;
  logic [15:0] cfg_wdata_v;

  function automatic logic [15:0] legacy(input logic [15:0] x);
    int ip;
    ip = int'($signed(x)) >>> 8;
    if (ip < -8) ip = -8;
    if (ip > 7) ip = 7;
    return LEGACY[ip + 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] x, input logic [3:0] tag, input logic [15:0] eg);
    q_x.push_back(x);
    q_tag.push_back(tag);
    q_eg.push_back(eg);
    q_et.push_back(tag);
  endtask

  task automatic cfg_write(input logic sel, input logic [3:0] addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Streams q_x/q_tag and scores outputs against q_eg/q_et; rdy_mode 1 toggles out_ready 1,0,0.
  task automatic run(input int rdy_mode, input string name);
    int          cyc = 0;
    int          budget;
    bit          prev_stall = 1'b0;
    logic [15:0] pg = '0;
    logic [3:0]  pt = '0;
    budget = q_eg.size() * 4 + 50;
    while (q_eg.size() > 0 && cyc < budget) begin
      in_valid  = (q_x.size() > 0);
      in_x      = (q_x.size() > 0) ? q_x[0] : 16'h0000;
      in_tag    = (q_tag.size() > 0) ? q_tag[0] : 4'h0;
      out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      cfg_we    = (cyc == cfg_cyc);
      cfg_sel   = cfg_sel_v;
      cfg_addr  = cfg_addr_v;
      cfg_wdata = cfg_wdata_v;
      @(negedge clk);
      chk({name, " in_ready"}, in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk({name, " stall valid"}, out_valid, 1);
        chk({name, " stall grad"}, out_grad, pg);
        chk({name, " stall tag"}, out_tag, pt);
      end
      if (out_valid && out_ready) begin
        chk({name, " grad"}, out_grad, q_eg.pop_front());
        chk({name, " tag"}, out_tag, q_et.pop_front());
      end
      if (in_valid && in_ready) begin
        void'(q_x.pop_front());
        void'(q_tag.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      pg = out_grad;
      pt = out_tag;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1; cfg_cyc = -1;
    chk({name, " drained"}, q_eg.size(), 0);
    q_x.delete(); q_tag.delete(); q_eg.delete(); q_et.delete();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, " no extra output"}, out_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    bit found;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_sel_v = 1'b0; cfg_addr_v = '0; cfg_wdata_v = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_grad", out_grad, 0);
    chk("reset out_tag", out_tag, 0);
    chk("reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Legacy equivalence: named codes, clamp edges, then a strided sweep.
    push(16'hff00, 4'h1, 16'h002a);
    push(16'h0180, 4'h2, 16'h005a);
    push(16'h0500, 4'h3, 16'h006e);
    push(16'hfa00, 4'h4, 16'h0000);
    push(16'h8000, 4'h5, 16'h0000);
    push(16'h7fff, 4'h6, 16'h006e);
    push(16'h07ff, 4'h7, 16'h006e);
    push(16'hf800, 4'h8, 16'h0000);
    push(16'h00ff, 4'h9, 16'h0044);
    for (int i = 0; i < 65536; i += 13)
      push(16'(i), 4'(i), legacy(16'(i)));
    run(0, "legacy");

    // Latency with out_ready held high.
    in_valid = 1'b1; in_x = 16'h0500; in_tag = 4'h5; out_ready = 1'b1;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        lat = k;
        chk("latency grad", out_grad, 16'h006e);
        chk("latency tag", out_tag, 4'h5);
      end
    end
    chk("latency cycles", lat, 3);
    @(posedge clk); #1;

    // Positive slope on segment 9.
    cfg_write(1'b1, 4'd9, 16'h000c);
    push(16'h0180, 4'h1, 16'h0060);
    push(16'h01ff, 4'h2, 16'h0065);
    push(16'h0100, 4'h3, 16'h005a);
    run(0, "linear");

    // Negative slope floors toward minus infinity.
    cfg_write(1'b1, 4'd9, 16'hfffd);
    push(16'h0101, 4'h4, 16'h0059);
    push(16'h01ff, 4'h5, 16'h0057);
    run(0, "floor");

    // c0[8] rewritten while the first sample reads it.
    cfg_cyc = 1; cfg_sel_v = 1'b0; cfg_addr_v = 4'd8; cfg_wdata_v = 16'h0050;
    push(16'h0020, 4'h1, 16'h0044);
    push(16'h0020, 4'h2, 16'h0050);
    run(0, "race");

    // Saturation at both ends.
    cfg_write(1'b0, 4'd15, 16'h7ff0);
    cfg_write(1'b1, 4'd15, 16'h0100);
    cfg_write(1'b0, 4'd8, 16'hfff0);
    cfg_write(1'b1, 4'd8, 16'h0000);
    push(16'h7f00, 4'h1, 16'h7fff);
    push(16'h0700, 4'h2, 16'h7ff0);
    push(16'h0780, 4'h3, 16'h7fff);
    push(16'h0000, 4'h4, 16'h0000);
    push(16'h00ff, 4'h5, 16'h0000);
    run(0, "saturate");

    // Backpressure over untouched segments.
    push(16'hff00, 4'h8, 16'h002a);
    push(16'hfe00, 4'h9, 16'h0014);
    push(16'hfd00, 4'ha, 16'h0008);
    push(16'hfc00, 4'hb, 16'h0003);
    push(16'h0200, 4'hc, 16'h0066);
    push(16'h0300, 4'hd, 16'h006b);
    push(16'h0400, 4'he, 16'h006d);
    push(16'hfb00, 4'hf, 16'h0001);
    run(1, "backpressure");

    // Reset with three samples in flight; the concurrent cfg write must be ignored.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_x = 16'h0200; in_tag = 4'(k + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd8; cfg_wdata = 16'h1234;
    @(negedge clk);
    chk("inflight out_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_grad", out_grad, 0);
    chk("midrst out_tag", out_tag, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst no stale", out_valid, 0);
    end
    @(posedge clk); #1;
    push(16'h0020, 4'h7, 16'h0044);
    push(16'h7f00, 4'h8, 16'h006e);
    run(0, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
